// File: rtl/wb_master_pid_mc_if.sv
// Wishbone master bus bundle used by wb_master_pid_mc.
interface wb_master_pid_mc_if #(
  parameter int AW = 16
);
  logic [AW-1:0] wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic          wbm_we_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic [3:0]    wbm_sel_o;
  logic          wbm_ack_i;
  logic          wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_sel_o,
    input  wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_sel_o,
    output wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/wb_master_pid_mc.sv
// Multi-channel PID register sweeper: snapshots per-channel kp/ki/kd/sp/pv,
// writes them to a Wishbone slave (skipping unchanged gains/setpoints),
// and clamps per-channel PID results into duty-cycle values.
module wb_master_pid_mc #(
  parameter int NCH            = 2,
  parameter int AW             = 16,
  parameter int CH_STRIDE      = 32,
  parameter int TIMEOUT        = 15,
  parameter int SKIP_UNCHANGED = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                enable_i,
  input  logic [NCH*32-1:0]   kp_input,
  input  logic [NCH*32-1:0]   ki_input,
  input  logic [NCH*32-1:0]   kd_input,
  input  logic [NCH*32-1:0]   sp_input,
  input  logic [NCH*32-1:0]   pv_input,
  input  logic [NCH*32-1:0]   period_input,
  input  logic [NCH*32-1:0]   pid_output,
  input  logic [NCH-1:0]      pid_valid,
  wb_master_pid_mc_if.master  wbm,
  output logic [NCH*32-1:0]   dcycle_o,
  output logic [NCH-1:0]      dcycle_vld_o,
  output logic                busy_o,
  output logic                err_o,
  input  logic                err_clr_i
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, REQ, WAIT, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ch, nxt_ch, sel_ch;
  logic [2:0]    idx, nxt_idx, sel_idx;
  logic [7:0]    tcnt;
  logic          last, need_wr, issue, ack_ok, fault, tmo;
  logic [31:0]   cur_dat;
  logic [31:0]   addr_full;

  logic [31:0]   snap       [NCH][5];
  logic [31:0]   shadow     [NCH][4];
  logic          shadow_vld [NCH][4];

  assign busy_o = (state != IDLE);

  // Sweep position bookkeeping, skip decision and bus-cycle issue conditions.
  // GAP looks ahead to the next register so a needed write starts straight
  // out of GAP, giving one low stb cycle between back-to-back transfers.
  always_comb begin
    nxt_idx = idx + 3'd1;
    nxt_ch  = ch;
    if (idx == 3'd4) begin
      nxt_idx = '0;
      nxt_ch  = ch + CW'(1);
    end
    last    = (idx == 3'd4) && (ch == CW'(NCH - 1));
    sel_ch  = (state == GAP) ? nxt_ch  : ch;
    sel_idx = (state == GAP) ? nxt_idx : idx;
    cur_dat = snap[sel_ch][sel_idx];
    need_wr = 1'b1;
    if ((SKIP_UNCHANGED != 0) && (sel_idx < 3'd4) &&
        shadow_vld[sel_ch][sel_idx[1:0]] &&
        (cur_dat == shadow[sel_ch][sel_idx[1:0]]))
      need_wr = 1'b0;
    addr_full = 32'(sel_ch) * 32'(CH_STRIDE) + 32'(sel_idx) * 32'd4;
    tmo       = (tcnt == 8'(TIMEOUT - 1));
    issue     = ((state == REQ) && need_wr) ||
                ((state == GAP) && !last && need_wr);
    fault     = (state == WAIT) && (wbm.wbm_err_i || (!wbm.wbm_ack_i && tmo));
    ack_ok    = (state == WAIT) && wbm.wbm_ack_i && !wbm.wbm_err_i;
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable_i) state_nxt = LATCH;
      LATCH: state_nxt = REQ;
      REQ:   if (need_wr) state_nxt = WAIT;
      WAIT:  if (wbm.wbm_ack_i || wbm.wbm_err_i || tmo) state_nxt = GAP;
      GAP: begin
        if (last)         state_nxt = IDLE;
        else if (need_wr) state_nxt = WAIT;
        else              state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, shadow, sweep index and registered Wishbone master outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ch            <= '0;
      idx           <= '0;
      tcnt          <= '0;
      err_o         <= 1'b0;
      wbm.wbm_adr_o <= '0;
      wbm.wbm_dat_o <= '0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_sel_o <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned r = 0; r < 5; r++) snap[c][r] <= '0;
        for (int unsigned r = 0; r < 4; r++) begin
          shadow[c][r]     <= '0;
          shadow_vld[c][r] <= 1'b0;
        end
      end
    end else begin
      case (state)
        LATCH: begin
          ch  <= '0;
          idx <= '0;
          for (int unsigned c = 0; c < NCH; c++) begin
            snap[c][0] <= kp_input[32*c +: 32];
            snap[c][1] <= ki_input[32*c +: 32];
            snap[c][2] <= kd_input[32*c +: 32];
            snap[c][3] <= sp_input[32*c +: 32];
            snap[c][4] <= pv_input[32*c +: 32];
          end
        end
        REQ: if (!need_wr) idx <= idx + 3'd1;
        WAIT: begin
          if (ack_ok || fault) begin
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
          if (ack_ok && (idx < 3'd4)) begin
            shadow[ch][idx[1:0]]     <= wbm.wbm_dat_o;
            shadow_vld[ch][idx[1:0]] <= 1'b1;
          end
          if (fault && (idx < 3'd4)) shadow_vld[ch][idx[1:0]] <= 1'b0;
        end
        GAP: if (!last) begin
          ch  <= nxt_ch;
          idx <= nxt_idx;
        end
        default: ;
      endcase
      if (issue) begin
        wbm.wbm_adr_o <= addr_full[AW-1:0];
        wbm.wbm_dat_o <= cur_dat;
        wbm.wbm_we_o  <= 1'b1;
        wbm.wbm_cyc_o <= 1'b1;
        wbm.wbm_stb_o <= 1'b1;
        wbm.wbm_sel_o <= 4'hF;
        tcnt          <= '0;
      end
      if (fault)          err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

  // Per-channel duty clamp: negative -> 0, above period -> period.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dcycle_o     <= '0;
      dcycle_vld_o <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        dcycle_vld_o[c] <= pid_valid[c];
        if (pid_valid[c]) begin
          if (pid_output[32*c+31])
            dcycle_o[32*c +: 32] <= '0;
          else if (pid_output[32*c +: 32] > period_input[32*c +: 32])
            dcycle_o[32*c +: 32] <= period_input[32*c +: 32];
          else
            dcycle_o[32*c +: 32] <= pid_output[32*c +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_master_pid_mc.sv
// Directed self-checking bench for wb_master_pid_mc (NCH=2).
module tb_wb_master_pid_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        err_clr_man, clr_on_fault, err_clr;
  logic        noack_all, noack_en, err_en;
  logic [15:0] noack_adr, err_adr;
  logic [63:0] kp, ki, kd, sp, pv, per, pid;
  logic [1:0]  pidv;
  logic [63:0] dcycle;
  logic [1:0]  dvld;
  logic        busy, err;

  int checks   = 0;
  int failures = 0;

  wb_master_pid_mc_if #(.AW(16)) wbm ();

  assign wbm.wbm_ack_i = wbm.wbm_cyc_o & wbm.wbm_stb_o & ~noack_all &
                         ~(noack_en & (wbm.wbm_adr_o == noack_adr));
  assign wbm.wbm_err_i = wbm.wbm_cyc_o & wbm.wbm_stb_o & err_en &
                         (wbm.wbm_adr_o == err_adr);
  assign err_clr = err_clr_man |
                   (clr_on_fault & wbm.wbm_stb_o & (wbm.wbm_adr_o == 16'd4));

  wb_master_pid_mc #(
    .NCH(2), .AW(16), .CH_STRIDE(32), .TIMEOUT(15), .SKIP_UNCHANGED(1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable),
    .kp_input(kp), .ki_input(ki), .kd_input(kd), .sp_input(sp), .pv_input(pv),
    .period_input(per), .pid_output(pid), .pid_valid(pidv),
    .wbm(wbm),
    .dcycle_o(dcycle), .dcycle_vld_o(dvld),
    .busy_o(busy), .err_o(err), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  // Bus monitor: one record per stb-high burst, taken on falling clock edges.
  logic [15:0] mon_adr[$];
  logic [31:0] mon_dat[$];
  int          mon_st[$];
  int          mon_len[$];
  bit          mon_err[$];
  int          cyc_n = 0;
  bit          prev_stb = 1'b0;
  int          cur_st, cur_len;
  logic [15:0] cur_a;
  logic [31:0] cur_d;
  bit          cur_e;

  always @(negedge clk) begin
    if (wbm.wbm_stb_o) begin
      if (!prev_stb) begin
        cur_st  = cyc_n;
        cur_len = 0;
        cur_e   = 1'b0;
        cur_a   = wbm.wbm_adr_o;
        cur_d   = wbm.wbm_dat_o;
      end
      cur_len++;
      if (wbm.wbm_err_i) cur_e = 1'b1;
    end else if (prev_stb) begin
      mon_adr.push_back(cur_a);
      mon_dat.push_back(cur_d);
      mon_st.push_back(cur_st);
      mon_len.push_back(cur_len);
      mon_err.push_back(cur_e);
    end
    prev_stb = wbm.wbm_stb_o;
    cyc_n++;
  end

  logic [15:0] ex_adr[$];
  logic [31:0] ex_dat[$];
  int          ex_len[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    mon_adr.delete(); mon_dat.delete(); mon_st.delete();
    mon_len.delete(); mon_err.delete();
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [31:0] d, input int len);
    ex_adr.push_back(a);
    ex_dat.push_back(d);
    ex_len.push_back(len);
  endtask

  task automatic run_sweep(input string tag);
    int n;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_log(input string tag, input bit chk_gap);
    chk({tag, "_count"}, mon_adr.size(), ex_adr.size());
    for (int i = 0; i < ex_adr.size() && i < mon_adr.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), mon_adr[i], ex_adr[i]);
      chk($sformatf("%s_dat%0d", tag, i), mon_dat[i], ex_dat[i]);
      chk($sformatf("%s_len%0d", tag, i), mon_len[i], ex_len[i]);
      if (chk_gap && i > 0)
        chk($sformatf("%s_gap%0d", tag, i), mon_st[i] - (mon_st[i-1] + mon_len[i-1]), 1);
    end
    ex_adr.delete(); ex_dat.delete(); ex_len.delete();
    mon_clear();
  endtask

  task automatic duty_step(input logic [31:0] p0, input logic [31:0] p1,
                           input logic [1:0] v, input logic [31:0] e0,
                           input logic [31:0] e1, input string tag);
    pid  = {p1, p0};
    pidv = v;
    @(negedge clk);
    chk({tag, "_dc0"}, dcycle[31:0], e0);
    chk({tag, "_dc1"}, dcycle[63:32], e1);
    chk({tag, "_vld"}, dvld, v);
    pidv = 2'b00;
    @(negedge clk);
    chk({tag, "_vld_drop"}, dvld, 2'b00);
    chk({tag, "_hold0"}, dcycle[31:0], e0);
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; err_clr_man = 1'b0; clr_on_fault = 1'b0;
    noack_all = 1'b0; noack_en = 1'b0; err_en = 1'b0;
    noack_adr = '0; err_adr = '0;
    kp = {32'h201, 32'h101}; ki = {32'h202, 32'h102};
    kd = {32'h203, 32'h103}; sp = {32'h204, 32'h104};
    pv = {32'h205, 32'h105};
    per = {32'd50, 32'd1000}; pid = '0; pidv = '0;
    repeat (3) @(negedge clk);

    chk("rst_cyc",  wbm.wbm_cyc_o, 1'b0);
    chk("rst_stb",  wbm.wbm_stb_o, 1'b0);
    chk("rst_we",   wbm.wbm_we_o, 1'b0);
    chk("rst_adr",  wbm.wbm_adr_o, 16'h0);
    chk("rst_dat",  wbm.wbm_dat_o, 32'h0);
    chk("rst_sel",  wbm.wbm_sel_o, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err",  err, 1'b0);
    chk("rst_dc",   dcycle, 64'h0);
    chk("rst_dvld", dvld, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    mon_clear();

    // Full first sweep: all ten registers, back to back.
    expect_wr(16'd0,  32'h101, 1); expect_wr(16'd4,  32'h102, 1);
    expect_wr(16'd8,  32'h103, 1); expect_wr(16'd12, 32'h104, 1);
    expect_wr(16'd16, 32'h105, 1); expect_wr(16'd32, 32'h201, 1);
    expect_wr(16'd36, 32'h202, 1); expect_wr(16'd40, 32'h203, 1);
    expect_wr(16'd44, 32'h204, 1); expect_wr(16'd48, 32'h205, 1);
    run_sweep("s1");
    check_log("s1", 1'b1);
    chk("s1_err", err, 1'b0);

    // Unchanged gains skipped; pv always written.
    pv[31:0] = 32'd7;
    expect_wr(16'd16, 32'd7, 1); expect_wr(16'd48, 32'h205, 1);
    run_sweep("s2");
    check_log("s2", 1'b0);

    ki[63:32] = 32'd5;
    expect_wr(16'd16, 32'd7, 1); expect_wr(16'd36, 32'd5, 1);
    expect_wr(16'd48, 32'h205, 1);
    run_sweep("s3");
    check_log("s3", 1'b0);

    // Slave ignores addr 8: stb held 15 cycles, fault, sweep continues.
    kd[31:0] = 32'h333;
    noack_en = 1'b1; noack_adr = 16'd8;
    expect_wr(16'd8, 32'h333, 15); expect_wr(16'd16, 32'd7, 1);
    expect_wr(16'd48, 32'h205, 1);
    run_sweep("s4");
    check_log("s4", 1'b0);
    chk("s4_err", err, 1'b1);

    noack_en = 1'b0;
    expect_wr(16'd8, 32'h333, 1); expect_wr(16'd16, 32'd7, 1);
    expect_wr(16'd48, 32'h205, 1);
    run_sweep("s5");
    check_log("s5", 1'b0);
    chk("s5_err_sticky", err, 1'b1);
    err_clr_man = 1'b1;
    @(negedge clk);
    err_clr_man = 1'b0;
    chk("s5_err_clr", err, 1'b0);

    // err and ack together at addr 4, with err_clr in the same cycle.
    ki[31:0] = 32'h444;
    err_en = 1'b1; err_adr = 16'd4; clr_on_fault = 1'b1;
    expect_wr(16'd4, 32'h444, 1); expect_wr(16'd16, 32'd7, 1);
    expect_wr(16'd48, 32'h205, 1);
    run_sweep("s6");
    chk("s6_err_seen", (mon_err.size() > 0) ? mon_err[0] : 1'b0, 1'b1);
    check_log("s6", 1'b0);
    chk("s6_err_set_wins", err, 1'b1);

    err_en = 1'b0; clr_on_fault = 1'b0;
    expect_wr(16'd4, 32'h444, 1); expect_wr(16'd16, 32'd7, 1);
    expect_wr(16'd48, 32'h205, 1);
    run_sweep("s7");
    check_log("s7", 1'b0);

    // Duty clamp; channel 1 period is 50.
    duty_step(32'd1500, 32'd60, 2'b11, 32'd1000, 32'd50, "d1500");
    duty_step(32'hFFFF_FFFD, 32'd60, 2'b01, 32'd0, 32'd50, "dneg");
    duty_step(32'd400, 32'd20, 2'b11, 32'd400, 32'd20, "d400");
    duty_step(32'd1000, 32'd9, 2'b01, 32'd1000, 32'd20, "deq");

    // Reset while a transfer is waiting on the slave.
    noack_all = 1'b1;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    n = 0;
    while (!wbm.wbm_stb_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rw_stb_seen", wbm.wbm_stb_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("rw_cyc", wbm.wbm_cyc_o, 1'b0);
    chk("rw_stb", wbm.wbm_stb_o, 1'b0);
    chk("rw_we",  wbm.wbm_we_o, 1'b0);
    chk("rw_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    noack_all = 1'b0;
    repeat (2) @(negedge clk);
    mon_clear();
    expect_wr(16'd0,  32'h101, 1); expect_wr(16'd4,  32'h444, 1);
    expect_wr(16'd8,  32'h333, 1); expect_wr(16'd12, 32'h104, 1);
    expect_wr(16'd16, 32'd7,   1); expect_wr(16'd32, 32'h201, 1);
    expect_wr(16'd36, 32'd5,   1); expect_wr(16'd40, 32'h203, 1);
    expect_wr(16'd44, 32'h204, 1); expect_wr(16'd48, 32'h205, 1);
    run_sweep("s8");
    check_log("s8", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_master_pid_mc.md
WB_MASTER_PID_MC -- requirements
Module: wb_master_pid_mc

Interface
REQ-001 SHALL have parameter NCH, default 2: number of PID channels (1..8).
REQ-002 SHALL have parameter AW, default 16: Wishbone address width.
REQ-003 SHALL have parameter CH_STRIDE, default 32: byte address stride between channel register banks.
REQ-004 SHALL have parameter TIMEOUT, default 15: max cycles stb waits for ack/err (1..255).
REQ-005 SHALL have parameter SKIP_UNCHANGED, default 1: 1 = suppress writes of unchanged kp/ki/kd/sp.
REQ-006 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-007 wb_rst_i  in  1  asynchronous active-high reset.
REQ-008 enable_i  in  1  level; high = run register sweeps back to back.
REQ-009 kp_input, ki_input, kd_input, sp_input, pv_input, period_input  in  NCH*32 each  per-channel values, channel c at bits [32c+31:32c].
REQ-010 pid_output  in  NCH*32  signed PID result per channel; pid_valid  in  NCH  per-channel qualifier.
REQ-011 wbm_adr_o  out  AW; wbm_dat_o  out  32; wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1; wbm_sel_o  out  4: registered Wishbone master outputs.
REQ-012 wbm_ack_i, wbm_err_i  in  1: slave termination.
REQ-013 dcycle_o  out  NCH*32  clamped duty per channel; dcycle_vld_o  out  NCH  one-cycle update strobes.
REQ-014 busy_o  out  1 (sweep in progress); err_o  out  1 sticky bus fault; err_clr_i  in  1 clears err_o.

Function
REQ-015 FSM states: IDLE, LATCH, REQ, WAIT, GAP; IDLE->LATCH when enable_i=1.
REQ-016 LATCH (1 cycle): capture all kp/ki/kd/sp/pv for all channels into snapshot regs; channel=0, reg index=0; ->REQ.
REQ-017 Register order per channel: kp (offset 0), ki (4), kd (8), sp (12), pv (16); address = c*CH_STRIDE + offset, truncated to AW.
REQ-018 REQ: if index<4, SKIP_UNCHANGED=1, shadow valid, snapshot==shadow -> no bus cycle, advance index same cycle; else drive adr/dat, we=1, cyc=stb=1, sel=4'hF at next edge, ->WAIT.
REQ-019 pv (index 4) SHALL always be written.
REQ-020 WAIT: at the edge where ack_i=1 sampled: cyc/stb/we<=0, shadow<=written value, shadow valid<=1, ->GAP.
REQ-021 WAIT: err_i=1 (priority over ack if both) or TIMEOUT cycles elapsed with no termination: cyc/stb/we<=0, err_o<=1, shadow not updated, ->GAP.
REQ-022 GAP (1 cycle, stb low): advance index; after pv advance channel; after pv of channel NCH-1 ->IDLE, else ->REQ.
REQ-023 Minimum transfer: 1 cycle stb high (ack sampled at first edge) + 1 GAP cycle.
REQ-024 enable_i deasserted mid-sweep SHALL NOT abort; sweep completes, then IDLE.
REQ-025 busy_o=1 in every state except IDLE.
REQ-026 err_clr_i=1 clears err_o; if a fault occurs the same cycle, err_o=1 (set wins).
REQ-027 Per channel c, on pid_valid[c]=1: dcycle[c]<=0 if pid_output[c][31]=1; else period_input[c] if pid_output[c] > period_input[c] (unsigned); else pid_output[c]; dcycle_vld_o[c]<=1 for one cycle.
REQ-028 pid_valid[c]=0: dcycle[c] holds, dcycle_vld_o[c]=0; channels independent of each other and of the FSM.

Reset
REQ-029 On wb_rst_i: FSM=IDLE, all Wishbone outputs 0, dcycle_o=0, dcycle_vld_o=0, busy_o=0, err_o=0, shadows=0 and invalid, snapshot=0.
REQ-030 Reset mid-transfer SHALL drop cyc/stb immediately (async); next sweep rewrites all registers.

Verification
REQ-031 NCH=2, reset, enable pulse, ack 1 cycle after stb: 10 writes, addrs 0,4,8,12,16,32,36,40,44,48, data = snapshot, each stb high 1 cycle, 1 low cycle between.
REQ-032 Second sweep, unchanged inputs, pv0=7 -> only addrs 16 (dat 7) and 48 written; change ki1 to 5 -> adds write 36 dat 5.
REQ-033 Slave never acks at addr 8: stb drops after 15 cycles, err_o=1, sweep continues to 12; next sweep rewrites addr 8; err_clr_i -> err_o=0.
REQ-034 err_i with ack same cycle at addr 4: err_o=1, ki shadow invalid, addr 4 rewritten next sweep.
REQ-035 period=1000; pid_output=-3 -> dcycle 0; 1500 -> 1000; 400 -> 400; each with one-cycle dcycle_vld_o; pid_valid=0 -> value held.
REQ-036 Assert wb_rst_i during WAIT: cyc/stb/we=0 within the same cycle, busy_o=0; after release and enable, full 10-write sweep.
